// File: rtl/flop_state_readback_if.sv
// Serial readback link: one data bit per valid/ready handshake.
interface flop_state_readback_if;
  logic ser_valid;
  logic ser_data;
  logic ser_ready;

  modport master (
    output ser_valid,
    output ser_data,
    input  ser_ready
  );

  modport slave (
    input  ser_valid,
    input  ser_data,
    output ser_ready
  );
endinterface

// File: rtl/flop_state_readback.sv
// Snapshots a register vector on request and streams it LSB first over a
// valid/ready link, optionally followed by an even-parity bit.
module flop_state_readback #(
  parameter int WIDTH     = 5,
  parameter int PARITY_EN = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  snap_req,
  input  logic [WIDTH-1:0]      state_in,
  flop_state_readback_if.master ser,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  state_e           after_data;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             overrun_q, overrun_d;
  logic             valid;
  logic             hs;
  logic             last_bit;

  generate
    if (PARITY_EN != 0) begin : g_par
      assign after_data = PAR;
    end else begin : g_nopar
      assign after_data = DONE;
    end
  endgenerate

  // Counter is wide enough to hold WIDTH, so WIDTH-1 never wraps (WIDTH=1 included).
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // All link outputs come from registered state only; state_in never reaches them.
  assign valid         = (state_q == SHIFT) || (state_q == PAR);
  assign hs            = valid & ser.ser_ready;
  assign ser.ser_valid = valid;
  assign ser.ser_data  = (state_q == SHIFT) ? shadow_q[0] :
                         (state_q == PAR)   ? par_q       : 1'b0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign overrun       = overrun_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          shadow_d  = state_in;
          cnt_d     = '0;
          par_d     = 1'b0;
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (snap_req) overrun_d = 1'b1;
        if (hs) begin
          shadow_d = shadow_q >> 1;
          par_d    = par_q ^ shadow_q[0];
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_bit) state_d = after_data;
        end
      end
      PAR: begin
        if (snap_req) overrun_d = 1'b1;
        if (hs) state_d = DONE;
      end
      DONE: begin
        if (snap_req) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flop_state_readback.sv
// Scoreboard bench for flop_state_readback: a 5-bit parity instance and a
// 1-bit no-parity instance, each checked by its own monitor.
module tb_flop_state_readback;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 5-bit, parity instance
  logic       snap_a;
  logic [4:0] sin_a;
  logic       busy_a, done_a, ovr_a;
  flop_state_readback_if ifa ();

  flop_state_readback #(.WIDTH(5), .PARITY_EN(1)) u_dut_a (
    .clk      (clk),
    .clr      (clr),
    .snap_req (snap_a),
    .state_in (sin_a),
    .ser      (ifa),
    .busy     (busy_a),
    .done     (done_a),
    .overrun  (ovr_a)
  );

  // 1-bit, no-parity instance
  logic       snap_b;
  logic [0:0] sin_b;
  logic       busy_b, done_b, ovr_b;
  flop_state_readback_if ifb ();

  flop_state_readback #(.WIDTH(1), .PARITY_EN(0)) u_dut_b (
    .clk      (clk),
    .clr      (clr),
    .snap_req (snap_b),
    .state_in (sin_b),
    .ser      (ifb),
    .busy     (busy_b),
    .done     (done_b),
    .overrun  (ovr_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state for instance A
  bit exp_a[$];
  bit ov_exp = 1'b0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int last_hs = -10;
  bit done_prev_a = 1'b0;

  always @(negedge clk) begin : mon_a
    bit e;
    if (!clr) begin
      if (ifa.ser_valid && ifa.ser_ready) begin
        check("a_bit_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_ser_data", 32'(ifa.ser_data), 32'(e));
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (ifa.ser_valid) check("a_busy_while_valid", 32'(busy_a), 32'd1);
      else               check("a_data_zero_idle", 32'(ifa.ser_data), 32'd0);
      check("a_overrun", 32'(ovr_a), 32'(ov_exp));
      if (done_a) begin
        check("a_done_all_bits_sent", 32'(exp_a.size()), 32'd0);
        check("a_done_after_last_hs", 32'(last_hs), 32'(cyc - 1));
        done_cnt++;
      end
      if (done_prev_a) check("a_idle_after_done", 32'(busy_a), 32'd0);
      done_prev_a = done_a;
    end
  end

  // Scoreboard state for instance B
  bit exp_b[$];
  int done_cnt_b = 0;
  int last_hs_b = -10;

  always @(negedge clk) begin : mon_b
    bit e;
    if (!clr) begin
      if (ifb.ser_valid && ifb.ser_ready) begin
        check("b_bit_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_ser_data", 32'(ifb.ser_data), 32'(e));
        end
        last_hs_b = cyc;
      end
      if (!ifb.ser_valid) check("b_data_zero_idle", 32'(ifb.ser_data), 32'd0);
      check("b_no_overrun", 32'(ovr_b), 32'd0);
      if (done_b) begin
        check("b_done_after_last_hs", 32'(last_hs_b), 32'(cyc - 1));
        done_cnt_b++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_a"},   32'(ifa.ser_valid), 32'd0);
    check({tag, "_data_a"},    32'(ifa.ser_data),  32'd0);
    check({tag, "_busy_a"},    32'(busy_a),        32'd0);
    check({tag, "_done_a"},    32'(done_a),        32'd0);
    check({tag, "_overrun_a"}, 32'(ovr_a),         32'd0);
  endtask

  // mode: 0 = ready high, 1 = ready pattern 1,0,0,..., 2 = random ready
  task automatic frame_a(input logic [4:0] val, input int mode, input int inj_at,
                         input int abort_after);
    int d0, hs0, k;
    @(posedge clk); #1;
    snap_a = 1'b1;
    sin_a  = val;
    @(posedge clk); #1;
    snap_a = 1'b0;
    sin_a  = 5'($urandom);
    ov_exp = 1'b0;
    for (int b = 0; b < 5; b++) exp_a.push_back(val[b]);
    exp_a.push_back(^val);
    check("a_valid_latency", 32'(ifa.ser_valid), 32'd1);
    d0 = done_cnt;
    hs0 = hs_cnt;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      case (mode)
        0:       ifa.ser_ready = 1'b1;
        1:       ifa.ser_ready = (k % 3 == 0);
        default: ifa.ser_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_after >= 0 && (hs_cnt - hs0) == abort_after) begin
        #2;
        clr = 1'b1;
        sin_a = 5'($urandom);
        ifa.ser_ready = 1'($urandom_range(0, 1));
        #1;
        check_reset_outputs("abort");
        exp_a.delete();
        ov_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        $display("frame A val=%b aborted after %0d bits", val, hs_cnt - hs0);
        return;
      end
      if (k == inj_at) begin
        snap_a = 1'b1;
        sin_a  = 5'b11111;
      end
      @(posedge clk); #1;
      if (snap_a) begin
        snap_a = 1'b0;
        ov_exp = 1'b1;
      end
      k++;
    end
    check("a_frame_timeout", 32'(k < 200), 32'd1);
    check("a_frame_handshakes", 32'(hs_cnt - hs0), 32'd6);
    $display("frame A val=%b mode=%0d inject=%0d cycles=%0d overrun=%0b",
             val, mode, inj_at, k, ovr_a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    snap_a = 1'b0; sin_a = 5'($urandom); ifa.ser_ready = 1'b1;
    snap_b = 1'b0; sin_b = 1'($urandom); ifb.ser_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    check("reset_valid_b", 32'(ifb.ser_valid), 32'd0);
    check("reset_busy_b",  32'(busy_b),        32'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    frame_a(5'b10110, 0, -1, -1);
    frame_a(5'b10110, 1, -1, -1);
    frame_a(5'b10110, 0, 2, -1);
    frame_a(5'b00000, 0, -1, -1);
    frame_a(5'b10110, 0, -1, 3);
    frame_a(5'b00001, 0, -1, -1);
    for (int i = 0; i < 20; i++) begin
      frame_a(5'($urandom), $urandom_range(0, 2),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1, -1);
    end

    // Back-to-back 1-bit frames: each snap_req lands in the cycle after DONE.
    ifb.ser_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      logic [0:0] v;
      v = 1'($urandom);
      snap_b = 1'b1;
      sin_b  = v;
      @(posedge clk); #1;
      snap_b = 1'b0;
      sin_b  = ~v;
      exp_b.push_back(v[0]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("frame B val=%b", v);
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_done_count", 32'(done_cnt_b), 32'd6);
    check("b_all_bits_sent", 32'(exp_b.size()), 32'd0);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
